// File: rtl/param_stack_pkg.sv
// +--------------------------------------------------------------------------+
// | param_stack_pkg : shared state encoding and default sizes for the stack  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package param_stack_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// +--------------------------------------------------------------------------+
// | stack_mem : DEPTH x WIDTH register file, sync write, async read.         |
// | Second read port present when PARAM_STACK_NOS_EN is defined.             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module stack_mem
   import param_stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_a_i,
   output logic [WIDTH-1:0]         rdata_a_o
`ifdef PARAM_STACK_NOS_EN
   ,
   input  logic [$clog2(DEPTH)-1:0] raddr_b_i,
   output logic [WIDTH-1:0]         rdata_b_o
`endif
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is deliberately not reset; contents are meaningless until pushed.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
`ifdef PARAM_STACK_NOS_EN
   assign rdata_b_o = mem_q[raddr_b_i];
`endif

endmodule

`default_nettype wire

// File: rtl/param_stack.sv
// +--------------------------------------------------------------------------+
// | param_stack : LIFO stack with push handshake, top-replace and underflow  |
// | flag. Optional macro PARAM_STACK_NOS_EN adds NOS_DAT and POP2_ACK.       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module param_stack
   import param_stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       CLR,
   input  logic                       PUSH_STB,
   input  logic [WIDTH-1:0]           PUSH_DAT,
   output logic                       PUSH_ACK,
   output logic                       POP_STB,
   output logic [WIDTH-1:0]           POP_DAT,
   input  logic                       POP_ACK,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       FULL,
   output logic                       EMPTY,
   output logic                       ERR_UNF
`ifdef PARAM_STACK_NOS_EN
   ,
   output logic [WIDTH-1:0]           NOS_DAT,
   input  logic                       POP2_ACK
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;

   logic            push_acc;
   logic            pop2_req;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [AW-1:0]   top_idx;
   logic [WIDTH-1:0] top_dat;

`ifdef PARAM_STACK_NOS_EN
   logic [AW-1:0]    nos_idx;
   logic [WIDTH-1:0] nos_dat;
   assign pop2_req = POP2_ACK;
   assign nos_idx  = (count_q < CW'(2)) ? '0 : AW'(count_q - CW'(2));
   assign NOS_DAT  = nos_dat;
`else
   assign pop2_req = 1'b0;
`endif

   assign top_idx = (count_q == '0) ? '0 : AW'(count_q - CW'(1));

   always_comb begin
      push_acc = PUSH_STB & ~ack_q & ~CLR & ~pop2_req
               & ((state_q != ST_FULL) | POP_ACK);
      count_d  = count_q;
      err_d    = err_q;
      we       = 1'b0;
      waddr    = top_idx;

      if (CLR) begin
         count_d = '0;
         err_d   = 1'b0;
      end else if (pop2_req) begin
         if (count_q >= CW'(2)) begin
            count_d = count_q - CW'(2);
         end else begin
            count_d = '0;
            err_d   = 1'b1;
         end
      end else if (push_acc) begin
         we = 1'b1;
         // Push with pop on a non-empty stack overwrites the top in place.
         if (POP_ACK && (state_q != ST_EMPTY)) begin
            waddr = top_idx;
         end else begin
            waddr   = AW'(count_q);
            count_d = count_q + CW'(1);
            if (POP_ACK) begin
               err_d = 1'b1;
            end
         end
      end else if (POP_ACK) begin
         if (state_q != ST_EMPTY) begin
            count_d = count_q - CW'(1);
         end else begin
            err_d = 1'b1;
         end
      end

      ack_d = push_acc;

      if (count_d == '0) begin
         state_d = ST_EMPTY;
      end else if (count_d == CW'(DEPTH)) begin
         state_d = ST_FULL;
      end else begin
         state_d = ST_PARTIAL;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_EMPTY;
         count_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i     (CLK),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (PUSH_DAT),
      .raddr_a_i (top_idx),
      .rdata_a_o (top_dat)
`ifdef PARAM_STACK_NOS_EN
      ,
      .raddr_b_i (nos_idx),
      .rdata_b_o (nos_dat)
`endif
   );

   assign PUSH_ACK = ack_q;
   assign POP_STB  = (state_q != ST_EMPTY);
   assign POP_DAT  = top_dat;
   assign COUNT    = count_q;
   assign FULL     = (state_q == ST_FULL);
   assign EMPTY    = (state_q == ST_EMPTY);
   assign ERR_UNF  = err_q;

endmodule

`default_nettype wire
